lsu_dmem_master: RTL and testbench
==================================

Name: lsu_dmem_master

Overview:
- Load/store unit that acts as the initiator on the data-memory port (word-wide memory; combinational read, write on posedge clk, single write enable).
- Accepts one CPU load/store request at a time: byte, halfword or word, signed or unsigned loads.
- Performs read-modify-write for sub-word stores, extracts and extends sub-word loads, and rejects misaligned accesses.
- Sits between the datapath and data memory; used when the core moves beyond the single-cycle datapath.

Parameters:
- RD_SYNC, 0, 0 = memory read data valid in the same cycle as the address; 1 = valid one cycle later (adds a WAIT state before every read capture).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned  in  1  zero-extend load (lbu/lhu)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  valid with resp_valid; misaligned or illegal size
- mem_addr  out  32  word address {addr_q[31:2],2'b00}
- mem_wd  out  32  write data
- mem_we  out  1  write enable
- mem_rd  in  32  read data

Behaviour:
- Reset values (asynchronous on rst_n low):
  - state = IDLE.
  - All internal registers = 0.
  - resp_valid = 0, resp_err = 0, resp_rdata = 0, mem_we = 0, mem_addr = 0, mem_wd = 0.
  - req_ready = 1.
- Byte lanes are little-endian: byte k (addr[1:0] = k) occupies mem word bits [8k+7:8k]; halfword at addr[1] occupies bits [16*addr[1]+15 : 16*addr[1]].
- Handshake:
  - A request is accepted on a rising edge where req_valid & req_ready.
  - The request fields are latched at acceptance; inputs are ignored until the block is back in IDLE.
- Alignment check at acceptance:
  - Error cases: half with addr[0] = 1; word with addr[1:0] ≠ 0; size = 3.
  - Error path goes to RESP with err_q = 1. No memory cycle is issued.
- States: IDLE, WAIT (RD_SYNC = 1 only), ACCESS, WRITE, RESP.
- ACCESS:
  - mem_addr is driven from the latched address.
  - Load: capture mem_rd, go to RESP.
  - Word store: mem_we = 1, mem_wd = wdata_q, go to RESP.
  - Sub-word store: capture mem_rd, go to WRITE.
- WRITE:
  - mem_we = 1; mem_wd = captured word with the selected lane(s) replaced by wdata_q[7:0] or wdata_q[15:0].
  - Go to RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle; resp_err = err_q.
  - resp_rdata = sign- or zero-extended lane, or 0 for stores and errors.
  - Then go to IDLE.
- WAIT (RD_SYNC = 1): inserted before every ACCESS that reads (loads and sub-word stores); mem_addr is held and mem_we = 0.
- Latency from the acceptance edge to resp_valid high (RD_SYNC = 0):
  - error: 1 cycle
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - RD_SYNC = 1 adds 1 cycle to loads and sub-word stores.
- mem_we is combinational from state and is high for exactly one cycle per legal store. It is never high on loads or errors.
- mem_addr and mem_wd hold their last values outside active states.
- No request is accepted in the RESP cycle. Back-to-back throughput is one request per (latency + 1) cycles.
- Reset mid-operation: mem_we drops immediately, no response is issued, the pending request is discarded, and the block is in IDLE after rst_n rises.
- Address 0xFFFFFFFC and above: no special handling; the word address is truncated as normal.

Test Plan:
- Preload word 0x8899AABB at address 8; lw addr 8 -> resp_valid 2 cycles after accept, resp_rdata = 0x8899AABB, resp_err = 0, mem_we stays 0.
- lb addr 9 -> 0xFFFFFFAA; lbu addr 9 -> 0x000000AA; lh addr 10 -> 0xFFFF8899; lhu addr 10 -> 0x00008899.
- sb addr 11, wdata 0x12 -> mem_we high for exactly one cycle (the WRITE state), word 8 becomes 0x1299AABB, resp at 3 cycles; then sw addr 8, wdata 0x0000000A -> word 8 = 0x0000000A, resp at 2 cycles.
- sh addr 9 and sw addr 10 -> resp_err = 1 one cycle after accept, resp_rdata = 0, mem_we never asserts, word 8 unchanged.
- Drive rst_n low during the WRITE state of sb addr 8 -> mem_we drops asynchronously, no resp_valid, memory unchanged; after release req_ready = 1 and the next lw returns correct data.
- Hold req_valid high across two queued loads (RD_SYNC = 0 and RD_SYNC = 1) -> the second is accepted only in IDLE after the first resp_valid; latencies are 2 and 3 cycles respectively.

Source files
------------

// File: rtl/lsu_dmem_master.sv
// lsu_dmem_master: load/store unit that initiates accesses on a word-wide data memory.
// Accepts one CPU load/store at a time (byte/half/word, signed/unsigned loads).
// Sub-word stores are done as read-modify-write, and sub-word loads are extracted and extended.
// Misaligned accesses and the illegal size code are rejected without a memory cycle.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready request handshake (req_ready high only in IDLE)
//   req_we              1 = store, 0 = load
//   req_size            0 byte, 1 half, 2 word, 3 illegal
//   req_unsigned        zero-extend sub-word loads
//   req_addr            byte address
//   req_wdata           right-justified store data
//   resp_valid          one-cycle completion pulse
//   resp_rdata          extended load data (0 for stores and errors)
//   resp_err            misaligned / illegal size, valid with resp_valid
//   mem_addr            word-aligned memory address
//   mem_wd, mem_we      memory write data / write enable
//   mem_rd              memory read data (same cycle, or one cycle late if RD_SYNC)
module lsu_dmem_master #(
  parameter int unsigned RD_SYNC = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  localparam int unsigned XLEN = 32;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_WRITE,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              err_q, err_d;
  logic [1:0]        lane_q, lane_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [XLEN-1:0]   rd_q, rd_d;
  logic [XLEN-1:0]   mem_addr_d, mem_wd_d;
  logic              misalign_c;
  logic              needs_read_c;

  // Replace the addressed byte or halfword lane of a memory word.
  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [15:0] data,
                                             input logic [1:0]  size,
                                             input logic [1:0]  lane);
    logic [31:0] r;
    r = word;
    if (size == SZ_B) r[{lane, 3'b000} +: 8] = data[7:0];
    else              r[{lane[1], 4'b0000} +: 16] = data;
    return r;
  endfunction

  // Select the addressed lane of a memory word and sign/zero extend it.
  function automatic logic [31:0] extract_lane(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      SZ_B:    r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      SZ_H:    r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign misalign_c = (req_size == 2'd3) ||
                      (req_size == SZ_H && req_addr[0]) ||
                      (req_size == SZ_W && req_addr[1:0] != 2'b00);
  // Loads and sub-word stores read memory; only word stores skip the read.
  assign needs_read_c = !req_we || (req_size != SZ_W);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      size_q   <= 2'd0;
      uns_q    <= 1'b0;
      err_q    <= 1'b0;
      lane_q   <= 2'd0;
      wdata_q  <= 16'd0;
      rd_q     <= '0;
      mem_addr <= '0;
      mem_wd   <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      err_q    <= err_d;
      lane_q   <= lane_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      mem_addr <= mem_addr_d;
      mem_wd   <= mem_wd_d;
    end
  end

  // Next-state and register updates.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    uns_d      = uns_q;
    err_d      = err_q;
    lane_d     = lane_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    mem_addr_d = mem_addr;
    mem_wd_d   = mem_wd;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          err_d   = misalign_c;
          lane_d  = req_addr[1:0];
          wdata_d = req_wdata[15:0];
          if (misalign_c) begin
            state_d = S_RESP;
          end else begin
            mem_addr_d = {req_addr[31:2], 2'b00};
            // Word store data is presented directly during ACCESS.
            if (req_we && req_size == SZ_W) mem_wd_d = req_wdata;
            if (RD_SYNC != 0 && needs_read_c) state_d = S_WAIT;
            else                              state_d = S_ACCESS;
          end
        end
      end
      S_WAIT: state_d = S_ACCESS;
      S_ACCESS: begin
        if (!we_q) begin
          rd_d    = mem_rd;
          state_d = S_RESP;
        end else if (size_q == SZ_W) begin
          state_d = S_RESP;
        end else begin
          mem_wd_d = merge_lane(mem_rd, wdata_q, size_q, lane_q);
          state_d  = S_WRITE;
        end
      end
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and memory strobes decode directly from the state register.
  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_err   = (state_q == S_RESP) && err_q;
  assign mem_we     = (state_q == S_WRITE) ||
                      (state_q == S_ACCESS && we_q && size_q == SZ_W);
  assign resp_rdata = (state_q == S_RESP && !we_q && !err_q) ?
                      extract_lane(rd_q, size_q, lane_q, uns_q) : '0;

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Testbench for lsu_dmem_master: two instances (RD_SYNC = 0 and 1), each with its own memory.
// A negedge monitor pairs each response with the queued expectation and checks data, error, latency and write-enable count.
module tb_lsu_dmem_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic        rdy0, rv0, err0, we0;
  logic [31:0] rdata0, ma0, wd0, mrd0;
  logic        rdy1, rv1, err1, we1;
  logic [31:0] rdata1, ma1, wd1, mrd1;

  logic [31:0] mem0 [16];
  logic [31:0] mem1 [16];
  logic [31:0] rd1_q;

  lsu_dmem_master #(.RD_SYNC(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid & ~sel), .req_ready(rdy0),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv0), .resp_rdata(rdata0), .resp_err(err0),
    .mem_addr(ma0), .mem_wd(wd0), .mem_we(we0), .mem_rd(mrd0)
  );

  lsu_dmem_master #(.RD_SYNC(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid & sel), .req_ready(rdy1),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv1), .resp_rdata(rdata1), .resp_err(err1),
    .mem_addr(ma1), .mem_wd(wd1), .mem_we(we1), .mem_rd(mrd1)
  );

  // Memory models: combinational read for dut0, registered read for dut1.
  assign mrd0 = mem0[ma0[5:2]];
  assign mrd1 = rd1_q;
  always @(posedge clk) if (we0) mem0[ma0[5:2]] <= wd0;
  always @(posedge clk) begin
    if (we1) mem1[ma1[5:2]] <= wd1;
    rd1_q <= mem1[ma1[5:2]];
  end

  logic        o_ready, o_resp, o_err, o_we;
  logic [31:0] o_rdata;
  assign o_ready = sel ? rdy1 : rdy0;
  assign o_resp  = sel ? rv1 : rv0;
  assign o_err   = sel ? err1 : err0;
  assign o_we    = sel ? we1 : we0;
  assign o_rdata = sel ? rdata1 : rdata0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nwe;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   we_cnt = 0;
  int   prev_resp_cyc = 0;
  int   last_resp_cyc = 0;
  int   last_acc_cyc = 0;
  exp_t m_e;
  int   m_a;
  int   m_lat;

  always @(posedge clk) cyc = cyc + 1;

  // Scoreboard monitor: accept edges, write strobes and responses, all sampled at negedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      we_cnt = 0;
    end else begin
      if (o_we) we_cnt = we_cnt + 1;
      if (o_resp) begin
        prev_resp_cyc = last_resp_cyc;
        last_resp_cyc = cyc;
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_resp cycle %0d", cyc);
        end else begin
          m_e = exp_q.pop_front();
          m_a = acc_q.pop_front();
          m_lat = cyc - m_a + 1;
          vectors++;
          if (o_rdata !== m_e.rdata) begin
            miscompares++;
            $display("FAIL resp_rdata got %h exp %h", o_rdata, m_e.rdata);
          end
          vectors++;
          if (o_err !== m_e.err) begin
            miscompares++;
            $display("FAIL resp_err got %b exp %b", o_err, m_e.err);
          end
          vectors++;
          if (m_lat != m_e.lat) begin
            miscompares++;
            $display("FAIL latency got %0d exp %0d", m_lat, m_e.lat);
          end
          vectors++;
          if (we_cnt != m_e.nwe) begin
            miscompares++;
            $display("FAIL mem_we_cycles got %0d exp %0d", we_cnt, m_e.nwe);
          end
        end
        we_cnt = 0;
      end
      if (req_valid && o_ready) begin
        acc_q.push_back(cyc + 1);
        last_acc_cyc = cyc + 1;
      end
    end
  end

  // Drive one request and wait for its acceptance edge; returns 1 time unit after that edge.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] erd, input logic eerr, input int elat,
                       input int enwe, input bit hold, input bit expect_resp);
    exp_t e;
    bit   ok;
    if (expect_resp) begin
      e.rdata = erd; e.err = eerr; e.lat = elat; e.nwe = enwe;
      exp_q.push_back(e);
    end
    req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (o_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout addr %h", addr);
    end
  endtask

  // Wait (bounded) until every queued expectation has been matched.
  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL resp_timeout pending %0d", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_size = 2'd0; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 16; i++) begin mem0[i] = '0; mem1[i] = '0; end
    mem0[2] = 32'h8899AABB;
    mem1[2] = 32'h8899AABB;
    #12;
    vectors++; if (rdy0 !== 1'b1)   begin miscompares++; $display("FAIL rst_ready got %b exp 1", rdy0); end
    vectors++; if (rv0 !== 1'b0)    begin miscompares++; $display("FAIL rst_resp_valid got %b exp 0", rv0); end
    vectors++; if (err0 !== 1'b0)   begin miscompares++; $display("FAIL rst_resp_err got %b exp 0", err0); end
    vectors++; if (rdata0 !== '0)   begin miscompares++; $display("FAIL rst_resp_rdata got %h exp 0", rdata0); end
    vectors++; if (we0 !== 1'b0)    begin miscompares++; $display("FAIL rst_mem_we got %b exp 0", we0); end
    vectors++; if (ma0 !== '0)      begin miscompares++; $display("FAIL rst_mem_addr got %h exp 0", ma0); end
    vectors++; if (wd0 !== '0)      begin miscompares++; $display("FAIL rst_mem_wd got %h exp 0", wd0); end
    vectors++; if (rdy1 !== 1'b1)   begin miscompares++; $display("FAIL rst_ready1 got %b exp 1", rdy1); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_loads();
    issue(1'b0, 2'd2, 1'b0, 32'd8,  '0, 32'h8899AABB, 1'b0, 2, 0, 1'b0, 1'b1); drain();
    issue(1'b0, 2'd0, 1'b0, 32'd9,  '0, 32'hFFFFFFAA, 1'b0, 2, 0, 1'b0, 1'b1); drain();
    issue(1'b0, 2'd0, 1'b1, 32'd9,  '0, 32'h000000AA, 1'b0, 2, 0, 1'b0, 1'b1); drain();
    issue(1'b0, 2'd1, 1'b0, 32'd10, '0, 32'hFFFF8899, 1'b0, 2, 0, 1'b0, 1'b1); drain();
    issue(1'b0, 2'd1, 1'b1, 32'd10, '0, 32'h00008899, 1'b0, 2, 0, 1'b0, 1'b1); drain();
    issue(1'b0, 2'd0, 1'b0, 32'd8,  '0, 32'hFFFFFFBB, 1'b0, 2, 0, 1'b0, 1'b1); drain();
    issue(1'b0, 2'd0, 1'b1, 32'd11, '0, 32'h00000088, 1'b0, 2, 0, 1'b0, 1'b1); drain();
  endtask

  task automatic test_stores();
    issue(1'b1, 2'd0, 1'b0, 32'd11, 32'h00000012, '0, 1'b0, 3, 1, 1'b0, 1'b1); drain();
    vectors++; if (mem0[2] !== 32'h1299AABB) begin miscompares++; $display("FAIL sb_word got %h exp 1299aabb", mem0[2]); end
    issue(1'b1, 2'd2, 1'b0, 32'd8, 32'h0000000A, '0, 1'b0, 2, 1, 1'b0, 1'b1); drain();
    vectors++; if (mem0[2] !== 32'h0000000A) begin miscompares++; $display("FAIL sw_word got %h exp 0000000a", mem0[2]); end
    issue(1'b1, 2'd1, 1'b0, 32'd10, 32'h1234BEEF, '0, 1'b0, 3, 1, 1'b0, 1'b1); drain();
    vectors++; if (mem0[2] !== 32'hBEEF000A) begin miscompares++; $display("FAIL sh_word got %h exp beef000a", mem0[2]); end
    issue(1'b0, 2'd1, 1'b0, 32'd10, '0, 32'hFFFFBEEF, 1'b0, 2, 0, 1'b0, 1'b1); drain();
    issue(1'b0, 2'd1, 1'b1, 32'd8,  '0, 32'h0000000A, 1'b0, 2, 0, 1'b0, 1'b1); drain();
  endtask

  task automatic test_misaligned();
    issue(1'b1, 2'd1, 1'b0, 32'd9,  32'hDEADBEEF, '0, 1'b1, 1, 0, 1'b0, 1'b1); drain();
    issue(1'b1, 2'd2, 1'b0, 32'd10, 32'hDEADBEEF, '0, 1'b1, 1, 0, 1'b0, 1'b1); drain();
    issue(1'b1, 2'd3, 1'b0, 32'd8,  32'hDEADBEEF, '0, 1'b1, 1, 0, 1'b0, 1'b1); drain();
    issue(1'b0, 2'd2, 1'b0, 32'd9,  '0,           '0, 1'b1, 1, 0, 1'b0, 1'b1); drain();
    vectors++; if (mem0[2] !== 32'hBEEF000A) begin miscompares++; $display("FAIL err_word got %h exp beef000a", mem0[2]); end
  endtask

  task automatic test_reset_mid();
    issue(1'b1, 2'd0, 1'b0, 32'd8, 32'h00000055, '0, 1'b0, 0, 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    vectors++; if (we0 !== 1'b1) begin miscompares++; $display("FAIL write_state_we got %b exp 1", we0); end
    rst_n = 1'b0;
    #1;
    vectors++; if (we0 !== 1'b0) begin miscompares++; $display("FAIL async_we_drop got %b exp 0", we0); end
    repeat (3) @(negedge clk);
    vectors++; if (rv0 !== 1'b0) begin miscompares++; $display("FAIL rst_no_resp got %b exp 0", rv0); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    acc_q.delete();
    #1;
    vectors++; if (rdy0 !== 1'b1) begin miscompares++; $display("FAIL post_rst_ready got %b exp 1", rdy0); end
    vectors++; if (mem0[2] !== 32'hBEEF000A) begin miscompares++; $display("FAIL rst_word got %h exp beef000a", mem0[2]); end
    @(posedge clk); #1;
    issue(1'b0, 2'd2, 1'b0, 32'd8, '0, 32'hBEEF000A, 1'b0, 2, 0, 1'b0, 1'b1); drain();
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    issue(1'b0, 2'd2, 1'b0, 32'd8,  '0, 32'hBEEF000A, 1'b0, 2, 0, 1'b1, 1'b1);
    vectors++; if (rdy0 !== 1'b0) begin miscompares++; $display("FAIL busy_ready got %b exp 0", rdy0); end
    issue(1'b0, 2'd0, 1'b0, 32'd11, '0, 32'hFFFFFFBE, 1'b0, 2, 0, 1'b0, 1'b1); drain();
    vectors++;
    if (last_acc_cyc != prev_resp_cyc + 2) begin
      miscompares++;
      $display("FAIL b2b_accept0 got %0d exp %0d", last_acc_cyc, prev_resp_cyc + 2);
    end
    sel = 1'b1;
    @(posedge clk); #1;
    issue(1'b0, 2'd2, 1'b0, 32'd8,  '0, 32'h8899AABB, 1'b0, 3, 0, 1'b1, 1'b1);
    issue(1'b0, 2'd1, 1'b0, 32'd10, '0, 32'hFFFF8899, 1'b0, 3, 0, 1'b0, 1'b1); drain();
    vectors++;
    if (last_acc_cyc != prev_resp_cyc + 2) begin
      miscompares++;
      $display("FAIL b2b_accept1 got %0d exp %0d", last_acc_cyc, prev_resp_cyc + 2);
    end
    issue(1'b1, 2'd0, 1'b0, 32'd9,  32'h00000077, '0, 1'b0, 4, 1, 1'b0, 1'b1); drain();
    vectors++; if (mem1[2] !== 32'h889977BB) begin miscompares++; $display("FAIL sync_sb_word got %h exp 889977bb", mem1[2]); end
    issue(1'b1, 2'd2, 1'b0, 32'd12, 32'hCAFEF00D, '0, 1'b0, 2, 1, 1'b0, 1'b1); drain();
    vectors++; if (mem1[3] !== 32'hCAFEF00D) begin miscompares++; $display("FAIL sync_sw_word got %h exp cafef00d", mem1[3]); end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_misaligned();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

endmodule
